// File: rtl/riscv_lsu_pkg.sv
// LSU operation codes, state encoding and request classification helpers.
// Bit 3 of a func marks a store; bits 1:0 give the access size.
package riscv_lsu_pkg;

   localparam logic [3:0] MEM_FUNC_LB  = 4'h0;
   localparam logic [3:0] MEM_FUNC_LH  = 4'h1;
   localparam logic [3:0] MEM_FUNC_LW  = 4'h2;
   localparam logic [3:0] MEM_FUNC_LBU = 4'h4;
   localparam logic [3:0] MEM_FUNC_LHU = 4'h5;
   localparam logic [3:0] MEM_FUNC_SB  = 4'h8;
   localparam logic [3:0] MEM_FUNC_SH  = 4'h9;
   localparam logic [3:0] MEM_FUNC_SW  = 4'hA;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_LOAD_WAIT,
      LSU_DONE
   } lsu_state_e;

   function automatic logic func_is_load(input logic [3:0] f);
      return f == MEM_FUNC_LB  || f == MEM_FUNC_LH  ||
             f == MEM_FUNC_LW  || f == MEM_FUNC_LBU ||
             f == MEM_FUNC_LHU;
   endfunction

   function automatic logic func_is_store(input logic [3:0] f);
      return f == MEM_FUNC_SB || f == MEM_FUNC_SH ||
             f == MEM_FUNC_SW;
   endfunction

   function automatic logic func_aligned(input logic [1:0] sz,
                                         input logic [1:0] off);
      case (sz)
         2'b00:   return 1'b1;
         2'b01:   return !off[0];
         default: return off == 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/riscv_load_extend.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it.
module riscv_load_extend
   import riscv_lsu_pkg::*;
(
   input  logic [3:0]  func,
   input  logic [1:0]  offset,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = rdata[7:0];
      case (offset)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      data = 32'h0;
      case (func)
         MEM_FUNC_LB:  data = {{24{b[7]}}, b};
         MEM_FUNC_LBU: data = {24'h0, b};
         MEM_FUNC_LH:  data = {{16{h[15]}}, h};
         MEM_FUNC_LHU: data = {16'h0, h};
         MEM_FUNC_LW:  data = rdata;
         default:      data = 32'h0;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: byte-lane masked BRAM access, one outstanding load,
// faults reported instead of touching memory.
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int DMEM_AW      = 14,
   parameter int DMEM_LATENCY = 2
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               flush_in,
   input  logic               req_valid_in,
   output logic               req_ready_out,
   input  logic [3:0]         mem_func_in,
   input  logic [31:0]        addr_in,
   input  logic [31:0]        store_data_in,
   input  logic [4:0]         rd_in,
   output logic               dmem_en_out,
   output logic [3:0]         dmem_we_out,
   output logic [DMEM_AW-1:0] dmem_addr_out,
   output logic [31:0]        dmem_wdata_out,
   input  logic [31:0]        dmem_rdata_in,
   output logic               resp_valid_out,
   output logic [31:0]        resp_data_out,
   output logic [4:0]         resp_rd_out,
   output logic               fault_out
);

   localparam logic [1:0] CNT_INIT = 2'(DMEM_LATENCY - 1);

   lsu_state_e  state, state_n;
   logic [1:0]  cnt, cnt_n;
   logic [3:0]  func_q, func_n;
   logic [1:0]  off_q, off_n;
   logic [4:0]  rd_q, rd_n;
   logic        valid_n, fault_n;
   logic [31:0] data_n, load_word;
   logic [4:0]  resp_rd_n;
   logic        accept, is_load, is_store, legal;
   logic [3:0]  lane_we;
   logic        unused_addr;

   assign unused_addr = ^addr_in[31:DMEM_AW+2];

   assign is_load  = func_is_load(mem_func_in);
   assign is_store = func_is_store(mem_func_in);
   assign legal    = (is_load || is_store) &&
                     func_aligned(mem_func_in[1:0], addr_in[1:0]);

   assign req_ready_out = !rst_in && state != LSU_LOAD_WAIT && !flush_in;
   assign accept        = req_valid_in && req_ready_out;
   assign dmem_en_out   = accept && legal;
   assign dmem_we_out   = (dmem_en_out && is_store) ? lane_we : 4'b0000;
   assign dmem_addr_out = addr_in[DMEM_AW+1:2];

   always_comb begin
      lane_we        = 4'b1111;
      dmem_wdata_out = store_data_in;
      case (mem_func_in[1:0])
         2'b00: begin
            lane_we        = 4'b0001 << addr_in[1:0];
            dmem_wdata_out = {4{store_data_in[7:0]}};
         end
         2'b01: begin
            lane_we        = addr_in[1] ? 4'b1100 : 4'b0011;
            dmem_wdata_out = {2{store_data_in[15:0]}};
         end
         default: begin
            lane_we        = 4'b1111;
            dmem_wdata_out = store_data_in;
         end
      endcase
   end

   riscv_load_extend u_ext (
      .func   (func_q),
      .offset (off_q),
      .rdata  (dmem_rdata_in),
      .data   (load_word)
   );

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      func_n    = func_q;
      off_n     = off_q;
      rd_n      = rd_q;
      valid_n   = 1'b0;
      data_n    = 32'h0;
      resp_rd_n = 5'd0;
      fault_n   = 1'b0;
      if (flush_in) begin
         state_n = LSU_IDLE;
         cnt_n   = 2'd0;
      end else if (state == LSU_LOAD_WAIT) begin
         if (cnt == 2'd0) begin
            state_n   = LSU_DONE;
            valid_n   = 1'b1;
            data_n    = load_word;
            resp_rd_n = rd_q;
         end else begin
            cnt_n = cnt - 2'd1;
         end
      end else if (accept) begin
         if (!legal) begin
            state_n = LSU_DONE;
            valid_n = 1'b1;
            fault_n = 1'b1;
         end else if (is_store) begin
            state_n = LSU_DONE;
            valid_n = 1'b1;
         end else begin
            state_n = LSU_LOAD_WAIT;
            cnt_n   = CNT_INIT;
            func_n  = mem_func_in;
            off_n   = addr_in[1:0];
            rd_n    = rd_in;
         end
      end else begin
         state_n = LSU_IDLE;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state          <= LSU_IDLE;
         cnt            <= 2'd0;
         func_q         <= 4'h0;
         off_q          <= 2'd0;
         rd_q           <= 5'd0;
         resp_valid_out <= 1'b0;
         resp_data_out  <= 32'h0;
         resp_rd_out    <= 5'd0;
         fault_out      <= 1'b0;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         func_q         <= func_n;
         off_q          <= off_n;
         rd_q           <= rd_n;
         resp_valid_out <= valid_n;
         resp_data_out  <= data_n;
         resp_rd_out    <= resp_rd_n;
         fault_out      <= fault_n;
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: behavioural BRAM, transaction-level
// model with per-cycle comparison, directed cases and random traffic.
module tb_riscv_lsu;
   import riscv_lsu_pkg::*;

   localparam int AW  = 14;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [3:0]    func = 4'h0;
   logic [31:0]   addr = 32'h0;
   logic [31:0]   sdata = 32'h0;
   logic [4:0]    rd = 5'd0;
   logic          dmem_en;
   logic [3:0]    dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [31:0]   dmem_wdata;
   logic [31:0]   dmem_rdata;
   logic          resp_valid;
   logic [31:0]   resp_data;
   logic [4:0]    resp_rd;
   logic          fault;

   always #5 clk = ~clk;

   riscv_lsu #(.DMEM_AW(AW), .DMEM_LATENCY(LAT)) dut (
      .clk_in         (clk),
      .rst_in         (rst),
      .flush_in       (flush),
      .req_valid_in   (req_valid),
      .req_ready_out  (req_ready),
      .mem_func_in    (func),
      .addr_in        (addr),
      .store_data_in  (sdata),
      .rd_in          (rd),
      .dmem_en_out    (dmem_en),
      .dmem_we_out    (dmem_we),
      .dmem_addr_out  (dmem_addr),
      .dmem_wdata_out (dmem_wdata),
      .dmem_rdata_in  (dmem_rdata),
      .resp_valid_out (resp_valid),
      .resp_data_out  (resp_data),
      .resp_rd_out    (resp_rd),
      .fault_out      (fault)
   );

   // Synchronous BRAM with LAT cycles of read latency
   logic [31:0] bram [int];
   logic [31:0] pipe [LAT] = '{default: 32'h0};
   logic [31:0] bw;
   assign dmem_rdata = pipe[LAT-1];

   always @(posedge clk) begin
      if (dmem_en) begin
         bw = bram.exists(int'(dmem_addr)) ? bram[int'(dmem_addr)] : 32'h0;
         pipe[0] <= bw;
         for (int i = 0; i < 4; i++)
            if (dmem_we[i]) bw[8*i +: 8] = dmem_wdata[8*i +: 8];
         bram[int'(dmem_addr)] = bw;
      end
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model state: expected responses keyed by cycle number
   int          busy_until = -1;
   bit          e_v  [int];
   logic [31:0] e_d  [int];
   logic [4:0]  e_rd [int];
   bit          e_f  [int];
   logic [31:0] ref_mem [int];
   bit          x_ready = 1'b0;
   bit          x_en = 1'b0;
   logic [3:0]  x_we = 4'h0;
   logic [AW-1:0] x_addr = '0;
   logic [31:0] x_wdata = 32'h0;

   int passed = 0;
   int total  = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)",
                    name, act, exp, cyc);
   endtask

   function automatic int size_of(logic [3:0] f);
      case (f)
         MEM_FUNC_LB, MEM_FUNC_LBU, MEM_FUNC_SB: return 1;
         MEM_FUNC_LH, MEM_FUNC_LHU, MEM_FUNC_SH: return 2;
         MEM_FUNC_LW, MEM_FUNC_SW:               return 4;
         default:                                return 0;
      endcase
   endfunction

   function automatic bit is_st(logic [3:0] f);
      return f == MEM_FUNC_SB || f == MEM_FUNC_SH || f == MEM_FUNC_SW;
   endfunction

   function automatic logic [31:0] mem_rd(int k);
      return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
   endfunction

   function automatic logic [31:0] model_load(logic [3:0] f,
                                              logic [1:0] off,
                                              logic [31:0] w);
      logic [31:0] s;
      s = w >> (8 * off);
      case (f)
         MEM_FUNC_LB:  return 32'($signed(s[7:0]));
         MEM_FUNC_LH:  return 32'($signed(s[15:0]));
         MEM_FUNC_LBU: return s & 32'hFF;
         MEM_FUNC_LHU: return s & 32'hFFFF;
         default:      return w;
      endcase
   endfunction

   task automatic add_exp(int c, logic [31:0] d, logic [4:0] r, bit f);
      e_v[c] = 1'b1;
      e_d[c] = d;
      e_rd[c] = r;
      e_f[c] = f;
   endtask

   task automatic clear_exp();
      e_v.delete();
      e_d.delete();
      e_rd.delete();
      e_f.delete();
   endtask

   task automatic step(bit v, logic [3:0] f, logic [31:0] a,
                       logic [31:0] d, logic [4:0] r, bit fl);
      int sz, key;
      bit acc, ok;
      logic [3:0] mask;
      logic [31:0] wd, w;
      @(negedge clk);
      req_valid = v;
      func = f;
      addr = a;
      sdata = d;
      rd = r;
      flush = fl;
      x_ready = !rst && (cyc > busy_until) && !fl;
      acc = v && x_ready;
      sz = size_of(f);
      ok = acc && sz != 0 && (int'(a[1:0]) % sz) == 0;
      key = int'(a[AW+1:2]);
      x_en = ok;
      x_we = 4'h0;
      x_addr = a[AW+1:2];
      x_wdata = 32'h0;
      if (fl) begin
         for (int k = cyc + 1; k <= cyc + LAT + 1; k++)
            if (e_v.exists(k)) begin
               e_v.delete(k);
               e_d.delete(k);
               e_rd.delete(k);
               e_f.delete(k);
            end
         if (busy_until > cyc) busy_until = cyc;
      end
      if (acc) begin
         if (!ok) begin
            add_exp(cyc + 1, 32'h0, 5'd0, 1'b1);
         end else if (is_st(f)) begin
            mask = 4'(((1 << sz) - 1) << a[1:0]);
            if (sz == 1)      wd = (d & 32'hFF) * 32'h0101_0101;
            else if (sz == 2) wd = (d & 32'hFFFF) * 32'h0001_0001;
            else              wd = d;
            x_we = mask;
            x_wdata = wd;
            w = mem_rd(key);
            for (int i = 0; i < 4; i++)
               if (mask[i]) w[8*i +: 8] = wd[8*i +: 8];
            ref_mem[key] = w;
            add_exp(cyc + 1, 32'h0, 5'd0, 1'b0);
         end else begin
            busy_until = cyc + LAT;
            add_exp(cyc + LAT + 1, model_load(f, a[1:0], mem_rd(key)),
                    r, 1'b0);
         end
      end
      #2;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0);
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      #1;
      chk("ready", 32'(req_ready), 32'(x_ready));
      chk("dmem_en", 32'(dmem_en), 32'(x_en));
      chk("dmem_we", 32'(dmem_we), 32'(x_we));
      if (x_en) chk("dmem_addr", 32'(dmem_addr), 32'(x_addr));
      if (x_we != 4'h0) chk("dmem_wdata", dmem_wdata, x_wdata);
      chk("resp_valid", 32'(resp_valid), 32'(e_v.exists(cyc)));
      if (e_v.exists(cyc)) begin
         chk("resp_data", resp_data, e_d[cyc]);
         chk("resp_rd", 32'(resp_rd), 32'(e_rd[cyc]));
         chk("fault", 32'(fault), 32'(e_f[cyc]));
      end
   end

   logic [3:0] funcs [11] = '{MEM_FUNC_LB, MEM_FUNC_LH, MEM_FUNC_LW,
                              MEM_FUNC_LBU, MEM_FUNC_LHU, MEM_FUNC_SB,
                              MEM_FUNC_SH, MEM_FUNC_SW, 4'h3, 4'hF, 4'hC};

   initial begin
      idle(2);
      chk("rst ready", 32'(req_ready), 32'h0);
      chk("rst resp_valid", 32'(resp_valid), 32'h0);
      rst = 1'b0;
      idle(1);
      chk("post-rst ready", 32'(req_ready), 32'h1);

      step(1, MEM_FUNC_SW, 32'h0000_0104, 32'hDEADBEEF, 5'd5, 0);
      chk("sw en", 32'(dmem_en), 32'h1);
      chk("sw we", 32'(dmem_we), 32'hF);
      chk("sw addr", 32'(dmem_addr), 32'h41);
      chk("sw wdata", dmem_wdata, 32'hDEADBEEF);
      idle(1);
      chk("sw done", 32'(resp_valid), 32'h1);
      chk("sw fault", 32'(fault), 32'h0);

      step(1, MEM_FUNC_SB, 32'h103, 32'h0000_00A5, 5'd7, 0);
      chk("sb we", 32'(dmem_we), 32'h8);
      chk("sb wdata", dmem_wdata, 32'hA5A5A5A5);
      step(1, MEM_FUNC_LB, 32'h103, 32'h0, 5'd9, 0);
      chk("lb en", 32'(dmem_en), 32'h1);
      idle(1);
      chk("lb wait ready", 32'(req_ready), 32'h0);
      idle(1);
      step(1, MEM_FUNC_LBU, 32'h103, 32'h0, 5'd10, 0);
      chk("lb data", resp_data, 32'hFFFFFFA5);
      chk("lb rd", 32'(resp_rd), 32'd9);
      idle(3);
      chk("lbu data", resp_data, 32'h000000A5);

      step(1, MEM_FUNC_SW, 32'h100, 32'h8001_1234, 5'd1, 0);
      step(1, MEM_FUNC_LH, 32'h102, 32'h0, 5'd3, 0);
      idle(1);
      chk("lh ready c1", 32'(req_ready), 32'h0);
      idle(1);
      chk("lh ready c2", 32'(req_ready), 32'h0);
      step(1, MEM_FUNC_LHU, 32'h102, 32'h0, 5'd3, 0);
      chk("lh ready c3", 32'(req_ready), 32'h1);
      chk("lh data", resp_data, 32'hFFFF8001);
      idle(3);
      chk("lhu data", resp_data, 32'h00008001);

      step(1, MEM_FUNC_LW, 32'h106, 32'h0, 5'd4, 0);
      chk("mis en", 32'(dmem_en), 32'h0);
      idle(1);
      chk("mis fault", 32'(fault), 32'h1);
      chk("mis data", resp_data, 32'h0);
      step(1, 4'hF, 32'h100, 32'h0, 5'd4, 0);
      chk("undef en", 32'(dmem_en), 32'h0);
      idle(1);
      chk("undef fault", 32'(fault), 32'h1);

      step(1, MEM_FUNC_LW, 32'h100, 32'h0, 5'd6, 0);
      step(0, 4'h0, 32'h0, 32'h0, 5'd0, 1);
      step(1, MEM_FUNC_SW, 32'h108, 32'h1122_3344, 5'd2, 0);
      chk("flush ready", 32'(req_ready), 32'h1);
      chk("flush sw en", 32'(dmem_en), 32'h1);
      idle(1);
      chk("flush rd", 32'(resp_rd), 32'h0);

      step(1, MEM_FUNC_LW, 32'h100, 32'h0, 5'd11, 0);
      idle(2);
      step(1, MEM_FUNC_LW, 32'h104, 32'h0, 5'd12, 0);
      chk("b2b data0", resp_data, 32'h8001_1234);
      idle(3);
      chk("b2b data1", resp_data, 32'hDEADBEEF);
      chk("b2b rd1", 32'(resp_rd), 32'd12);

      step(1, MEM_FUNC_LW, 32'h100, 32'h0, 5'd13, 0);
      idle(1);
      #1;
      rst = 1'b1;
      #1;
      chk("arst valid", 32'(resp_valid), 32'h0);
      chk("arst data", resp_data, 32'h0);
      chk("arst rd", 32'(resp_rd), 32'h0);
      chk("arst fault", 32'(fault), 32'h0);
      chk("arst en", 32'(dmem_en), 32'h0);
      chk("arst ready", 32'(req_ready), 32'h0);
      clear_exp();
      busy_until = -1;
      idle(1);
      rst = 1'b0;
      idle(3);

      for (int n = 0; n < 800; n++) begin
         logic [31:0] a;
         a = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 63));
         step($urandom_range(0, 9) < 7, funcs[$urandom_range(0, 10)], a,
              $urandom(), 5'($urandom_range(1, 31)),
              $urandom_range(0, 19) == 0);
      end
      idle(LAT + 2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Memory-access stage directly downstream of riscv_alu.
- Takes the ALU result as the effective address and rs2 as store data.
- Issues byte-lane-masked accesses to a synchronous data BRAM and returns sign/zero-extended load data with the destination register for writeback.
- Multi-cycle: holds off upstream via ready while a load is outstanding; flags misaligned or illegal accesses instead of touching memory.

Parameters:
- DMEM_AW, 14: word-address width of the data memory port.
- DMEM_LATENCY, 2: BRAM read latency in cycles, legal range 1..4.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- flush_in  input  1  synchronous kill of any pending response
- req_valid_in  input  1  request present
- req_ready_out  output  1  request accepted when valid&ready at rising edge
- mem_func_in  input  4  MEM_FUNC_* operation code
- addr_in  input  32  effective byte address (ALU result_out)
- store_data_in  input  32  rs2 value
- rd_in  input  5  destination register
- dmem_en_out  output  1  memory enable
- dmem_we_out  output  4  per-byte write enables
- dmem_addr_out  output  DMEM_AW  word address, addr_in[DMEM_AW+1:2]
- dmem_wdata_out  output  32  lane-replicated store data
- dmem_rdata_in  input  32  BRAM read word
- resp_valid_out  output  1  one-cycle completion pulse
- resp_data_out  output  32  extended load data; 0 for stores and faults
- resp_rd_out  output  5  destination register; 0 for stores and faults
- fault_out  output  1  valid with resp_valid_out: misaligned or illegal func

Behaviour:
- Clock and reset are fixed: one clock clk_in; rst_in is asynchronous and active-high.
- Reset:
  - State is IDLE.
  - All registered outputs are 0: resp_valid_out, resp_data_out, resp_rd_out, fault_out.
  - dmem_en_out and dmem_we_out are 0; req_ready_out is 1 after reset deasserts.
  - Reset mid-load drops the response. A write already issued is not undone.
- States:
  - IDLE: ready.
  - LOAD_WAIT: counter counts DMEM_LATENCY-1 down to 0; not ready.
  - DONE: resp_valid_out high for exactly one cycle; ready.
- req_ready_out = (IDLE or DONE) and !flush_in.
- Accept cycle, cycle 0: dmem_* outputs are driven combinationally from the request, only when accepted and legal.
- Store accepted in cycle 0:
  - Write happens in cycle 0.
  - DONE is in cycle 1, with resp_valid_out=1, data=0, rd=0.
- Load accepted in cycle 0:
  - dmem_en_out=1 and dmem_we_out=0 in cycle 0.
  - dmem_rdata_in is sampled at the end of cycle DMEM_LATENCY.
  - resp_valid_out=1 in cycle DMEM_LATENCY+1.
  - Latch rd, func and addr[1:0] at accept.
- Lane rules:
  - SB: we=1<<addr[1:0], wdata={4{b}}.
  - SH: we=0011 when addr[1]=0, else 1100; wdata={2{h}}.
  - SW: we=1111.
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LW takes the full word. LB and LH sign-extend, LBU and LHU zero-extend.
- Fault conditions: halfword with addr[0]=1, word with addr[1:0]!=0, or an undefined func.
  - No memory access: en=0, we=0.
  - Next cycle goes to DONE with fault_out=1, data=0, rd=0.
- Back-to-back: a request accepted in DONE is handled as from IDLE; the DONE pulse is still emitted.
- flush_in:
  - Blocks acceptance that cycle.
  - In LOAD_WAIT or DONE, it forces IDLE at the next edge and suppresses resp_valid_out. If asserted in a DONE cycle, the pulse already being driven that cycle is still seen.
  - Counter resets.
- Unaligned address bits above DMEM_AW+1 are ignored (wrap).

Decomposition:
- Add MEM_FUNC_LB/LH/LW/LBU/LHU/SB/SH/SW (4-bit) and the LSU state encoding to riscv_constants.sv, alongside the ALU_FUNC/BR_FUNC defines.
- One combinational sub-module, riscv_load_extend: inputs func, offset[1:0], rdata; output extended word. It is reused by any future cache path.

Test Plan:
- SW addr=0x0000_0104, data=0xDEADBEEF -> cycle 0: en=1, we=1111, dmem_addr=0x41, wdata=0xDEADBEEF; cycle 1: resp_valid=1, fault=0.
- SB addr=0x103, data=0x000000A5 then LB addr=0x103 with memory byte 0xA5 -> we=1000, wdata=0xA5A5A5A5; load returns 0xFFFFFFA5, LBU returns 0x000000A5; resp_valid in cycle 3 for DMEM_LATENCY=2.
- LH addr=0x102, word 0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001; ready low in cycles 1–2, high in cycle 3.
- LW addr=0x106 -> en=0, we=0, next cycle resp_valid=1, fault=1, data=0; undefined func 4'hF behaves the same.
- LW issued, flush_in pulsed in cycle 1 -> no resp_valid; ready high in cycle 2; a new SW is accepted.
- LW issued, rst_in asserted asynchronously mid-cycle 1 -> all outputs 0 immediately; no response after release; back-to-back loads with DMEM_LATENCY=1 return data on consecutive DONE cycles.
